temp_sample_filter: RTL
=======================

Name: temp_sample_filter

Overview:
- Downstream consumer of the SPI temperature-read controller.
- Takes each 16-bit little-endian-assembled ADXL362 temperature word (12-bit two's complement, sign-extended) on a one-cycle strobe.
- Produces a block average over 2^AVG_LOG2 samples with a valid/ready handshake, running min/max, and an over-temperature alarm with hysteresis.
- Output feeds the reporting/display stage.

Parameters:
- AVG_LOG2, 3, log2 of samples per average (legal range 0..8).
- TEMP_W, 12, significant signed temperature width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- temp_in  input  16  raw temperature word; bits [15:TEMP_W] must equal bit [TEMP_W-1]
- temp_valid  input  1  one-cycle strobe, temp_in valid
- hi_thresh  input  TEMP_W  signed alarm-set threshold
- lo_thresh  input  TEMP_W  signed alarm-clear threshold
- clear_stats  input  1  clears min/max, overrun and sample_err_cnt
- avg_out  output  TEMP_W  signed block average
- avg_valid  output  1  avg_out holds an unconsumed average
- avg_ready  input  1  downstream accepts avg_out
- min_out  output  TEMP_W  signed minimum since reset/clear
- max_out  output  TEMP_W  signed maximum since reset/clear
- stats_valid  output  1  min/max hold at least one sample
- alarm  output  1  over-temperature alarm
- overrun  output  1  sticky: unconsumed average overwritten
- sample_err  output  1  one-cycle pulse: malformed sample discarded
- sample_err_cnt  output  8  saturating malformed-sample count

Behaviour:
- Reset (async assert, sync release): all outputs 0; accumulator 0; sample count 0.
- Sample check: a sample with temp_valid=1 whose bits [15:TEMP_W] are not all equal to bit [TEMP_W-1] is discarded.
  - The cycle after a discard, sample_err pulses.
  - sample_err_cnt increments and saturates at 255.
  - A discarded sample does not touch the accumulator or min/max.
- Accumulator:
  - Signed, width TEMP_W+AVG_LOG2; cannot overflow.
  - The sample counter is AVG_LOG2 bits wide (when AVG_LOG2=0, every sample is a block).
  - On the good sample that completes a block:
    - avg = (acc + sample) >>> AVG_LOG2, arithmetic shift, floor rounding.
    - The accumulator and counter clear in the same cycle.
- Output register:
  - avg_out and avg_valid update on the clk edge after the completing sample (latency 1).
  - avg_valid stays high until a cycle with avg_valid && avg_ready, which clears it.
  - If a new average lands while avg_valid=1 and avg_ready=0: overwrite avg_out, keep avg_valid=1, set overrun.
  - If the new average lands in the same cycle as the handshake: load the new value, avg_valid stays 1, no overrun.
- Alarm:
  - Evaluated only when a new average is loaded.
  - Set if avg > hi_thresh (signed).
  - Cleared if avg < lo_thresh (signed).
  - Otherwise held.
  - If lo_thresh > hi_thresh, set takes priority.
- Min/max:
  - Updated on every good sample, signed compare; registered, 1-cycle latency.
  - The first good sample after reset or clear loads both min and max and sets stats_valid.
- clear_stats:
  - Clears min_out, max_out, stats_valid, overrun and sample_err_cnt.
  - Does not affect the accumulator, avg_out, avg_valid or alarm.
  - Simultaneous clear_stats and a good sample: the sample loads min and max, and stats_valid=1.
- FSM for the stats register:
  - S_EMPTY (stats_valid=0) -> S_TRACK on a good sample.
  - S_TRACK -> S_EMPTY on clear_stats without a good sample.
- Reset mid-block discards the partial accumulation; the next block starts at count 0.

Decomposition:
- Shared package temp_pkg holds:
  - TEMP_W
  - the sign-extension check function
  - FSM state encodings S_EMPTY/S_TRACK
  - the default thresholds used by the top level
- One sub-module, temp_minmax_tracker: the min/max registers, the FSM and clear_stats handling.
- The accumulator, handshake and alarm stay in temp_sample_filter.

Test Plan:
- AVG_LOG2=2; samples 0x0010,0x0020,0x0030,0x0040; avg_ready=1 -> avg_out=0x028, avg_valid pulses 1 cycle; min=0x010, max=0x040.
- AVG_LOG2=2; samples 0xFFFF,0xFFFE,0xFFFE,0xFFFE -> sum -7, avg_out=0xFFE (-2, floor); min=0xFFE, max=0xFFF.
- hi=0x100, lo=0x0F0; block averages 0x0F8, 0x101, 0x0F5, 0x0EF -> alarm after each: 0, 1, 1, 0.
- temp_in=0x1005 strobed mid-block -> sample_err pulse, sample_err_cnt=1, and the block average is unchanged versus the same stream without it.
- Backpressure: avg_ready=0 across two completed blocks -> second average in avg_out, overrun=1; clear_stats -> overrun=0, avg_valid still 1.
- Reset asserted after 2 of 4 samples -> outputs 0; the next 4 samples 0x0008 each -> avg_out=0x008.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared definitions for the temperature sample filter: widths, stats FSM states,
// default alarm thresholds and the sample sign-extension check.
package temp_pkg;

   localparam int TEMP_W = 12;
   localparam int RAW_W  = 16;

   localparam logic [TEMP_W-1:0] DEF_HI_THRESH = 12'h7FF;
   localparam logic [TEMP_W-1:0] DEF_LO_THRESH = 12'h800;

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_TRACK = 1'b1
   } stats_state_t;

   // A well-formed word has every bit above the sign bit equal to the sign bit,
   // i.e. shifting the sign bit down leaves all zeros or all ones.
   function automatic logic sample_ok(input logic [RAW_W-1:0] word, input int width);
      logic signed [RAW_W-1:0] ext;
      ext = $signed(word) >>> (width - 1);
      return (ext == '0) || (ext == '1);
   endfunction

endpackage

// File: rtl/temp_minmax_tracker.sv
// Running signed min/max over good samples, with an EMPTY/TRACK state that
// gates stats_valid and a clear that restarts tracking.
module temp_minmax_tracker
   import temp_pkg::*;
#(
   parameter int W = TEMP_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         sample_valid,
   input  logic [W-1:0] sample,
   input  logic         clear,
   output logic [W-1:0] min_out,
   output logic [W-1:0] max_out,
   output logic         stats_valid
);

   stats_state_t state_reg, state_next;
   logic [W-1:0] min_reg, min_next;
   logic [W-1:0] max_reg, max_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_EMPTY;
         min_reg   <= '0;
         max_reg   <= '0;
      end else begin
         state_reg <= state_next;
         min_reg   <= min_next;
         max_reg   <= max_next;
      end
   end

   // A sample arriving together with clear starts a fresh window with that sample.
   always_comb begin
      state_next = state_reg;
      min_next   = min_reg;
      max_next   = max_reg;
      if (sample_valid) begin
         state_next = S_TRACK;
         if (clear || state_reg == S_EMPTY) begin
            min_next = sample;
            max_next = sample;
         end else begin
            if ($signed(sample) < $signed(min_reg)) min_next = sample;
            if ($signed(sample) > $signed(max_reg)) max_next = sample;
         end
      end else if (clear) begin
         state_next = S_EMPTY;
         min_next   = '0;
         max_next   = '0;
      end
   end

   assign min_out     = min_reg;
   assign max_out     = max_reg;
   assign stats_valid = (state_reg == S_TRACK);

endmodule

// File: rtl/temp_sample_filter.sv
// Block-averaging temperature filter: malformed-sample rejection, 2^AVG_LOG2
// block average with valid/ready output, hysteresis alarm and min/max stats.
module temp_sample_filter #(
   parameter int AVG_LOG2 = 3,
   parameter int TEMP_W   = temp_pkg::TEMP_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       temp_in,
   input  logic              temp_valid,
   input  logic [TEMP_W-1:0] hi_thresh,
   input  logic [TEMP_W-1:0] lo_thresh,
   input  logic              clear_stats,
   output logic [TEMP_W-1:0] avg_out,
   output logic              avg_valid,
   input  logic              avg_ready,
   output logic [TEMP_W-1:0] min_out,
   output logic [TEMP_W-1:0] max_out,
   output logic              stats_valid,
   output logic              alarm,
   output logic              overrun,
   output logic              sample_err,
   output logic [7:0]        sample_err_cnt
);
   import temp_pkg::*;

   localparam int ACC_W = TEMP_W + AVG_LOG2;
   localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   logic                     word_ok, good_sample, bad_sample, block_done;
   logic signed [TEMP_W-1:0] sample, avg_new;
   logic signed [ACC_W-1:0]  acc_reg, acc_next, sum;
   logic [CNT_W-1:0]         cnt_reg, cnt_next;
   logic [TEMP_W-1:0]        avg_reg, avg_next;
   logic                     avg_valid_reg, avg_valid_next;
   logic                     alarm_reg, alarm_next;
   logic                     overrun_reg, overrun_next;
   logic                     err_pulse_reg, err_pulse_next;
   logic [7:0]               err_cnt_reg, err_cnt_next;

   assign word_ok     = sample_ok(temp_in, TEMP_W);
   assign good_sample = temp_valid && word_ok;
   assign bad_sample  = temp_valid && !word_ok;
   assign sample      = temp_in[TEMP_W-1:0];

   // Accumulator is wide enough for a full block of extreme samples.
   assign sum     = acc_reg + ACC_W'(sample);
   assign avg_new = TEMP_W'(sum >>> AVG_LOG2);

   generate
      if (AVG_LOG2 == 0) begin : g_single
         assign block_done = good_sample;
      end else begin : g_multi
         assign block_done = good_sample && (cnt_reg == '1);
      end
   endgenerate

   always_comb begin
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      avg_next       = avg_reg;
      avg_valid_next = avg_valid_reg;
      alarm_next     = alarm_reg;
      overrun_next   = overrun_reg && !clear_stats;
      err_pulse_next = bad_sample;
      err_cnt_next   = err_cnt_reg;

      if (good_sample) begin
         if (block_done) begin
            acc_next = '0;
            cnt_next = '0;
         end else begin
            acc_next = sum;
            cnt_next = cnt_reg + CNT_W'(1);
         end
      end

      // A new average always wins; it overwrites an unconsumed one only
      // when there is no handshake this cycle.
      if (block_done) begin
         avg_next       = avg_new;
         avg_valid_next = 1'b1;
         if (avg_valid_reg && !avg_ready) overrun_next = 1'b1;
         if (avg_new > $signed(hi_thresh))      alarm_next = 1'b1;
         else if (avg_new < $signed(lo_thresh)) alarm_next = 1'b0;
      end else if (avg_valid_reg && avg_ready) begin
         avg_valid_next = 1'b0;
      end

      if (clear_stats)                           err_cnt_next = '0;
      else if (bad_sample && err_cnt_reg != '1)  err_cnt_next = err_cnt_reg + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_reg       <= '0;
         cnt_reg       <= '0;
         avg_reg       <= '0;
         avg_valid_reg <= 1'b0;
         alarm_reg     <= 1'b0;
         overrun_reg   <= 1'b0;
         err_pulse_reg <= 1'b0;
         err_cnt_reg   <= '0;
      end else begin
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         avg_reg       <= avg_next;
         avg_valid_reg <= avg_valid_next;
         alarm_reg     <= alarm_next;
         overrun_reg   <= overrun_next;
         err_pulse_reg <= err_pulse_next;
         err_cnt_reg   <= err_cnt_next;
      end
   end

   temp_minmax_tracker #(.W(TEMP_W)) u_minmax (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (good_sample),
      .sample       (sample),
      .clear        (clear_stats),
      .min_out      (min_out),
      .max_out      (max_out),
      .stats_valid  (stats_valid)
   );

   assign avg_out        = avg_reg;
   assign avg_valid      = avg_valid_reg;
   assign alarm          = alarm_reg;
   assign overrun        = overrun_reg;
   assign sample_err     = err_pulse_reg;
   assign sample_err_cnt = err_cnt_reg;

endmodule
